// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the serial shift link receiver.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESYNC
  } shift_rx_state_t;

  localparam int ERR_CNT_W = 8;

  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/shift_rx.sv
// Serial-in/parallel-out receiver: word lands in q one edge after its eos bit, with frame-length check.
// No backpressure: en qualifies every bit, en=0 cycles are gaps that only clear the status pulses.
module shift_rx
  import shift_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sdi,
  input  logic                 eos,
  output logic [BITS-1:0]      q,
  output logic                 q_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CW = cnt_width(BITS);

  shift_rx_state_t      state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BITS-1:0]      sr_q, sr_d;
  logic [BITS-1:0]      q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [BITS-1:0] sr_shift;
  logic [CW-1:0]   cnt_plus;
  logic            last_bit;

  // Shifted word including the bit on sdi this cycle.
  assign sr_shift = (MSB_FIRST != 0) ? {sr_q[BITS-2:0], sdi} : {sdi, sr_q[BITS-1:1]};
  assign cnt_plus = cnt_q + 1'b1;
  assign last_bit = (cnt_plus == CW'(BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (!eos) begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
          end
        end
        SHIFT: begin
          if (eos || last_bit) begin
            cnt_d   = '0;
            state_d = eos ? IDLE : RESYNC;
          end else begin
            cnt_d = cnt_plus;
          end
        end
        RESYNC: begin
          if (eos) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d        = en ? sr_shift : sr_q;
    q_d         = q_q;
    q_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    if (en) begin
      case (state_q)
        IDLE:  frame_err_d = eos;
        SHIFT: begin
          if (eos && last_bit) begin
            q_d       = sr_shift;
            q_valid_d = 1'b1;
          end else if (eos || last_bit) begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    err_cnt_d = (frame_err_d && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
  assign err_cnt   = err_cnt_q;

endmodule
